// File: rtl/demux_stream_pkg.sv
// Shared constants and helpers for the stream mux/demux register blocks.
// Word width follows the Hack machine word; counters are a fixed 16 bits.
package demux_stream_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int COUNT_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Channel counts are restricted to 2, 4 or 8 so every select code maps to a real slot.
    function automatic bit legal_channels(input int n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry channel buffer: loads a word, holds it until its consumer takes it.
// Latency 1 cycle load-to-valid; a take and a load in the same cycle keep the slot full.
// Backpressure: the slot never refuses a load itself; the top gates loads with its ready term.
// Optional per-slot delivered-word counter under DEMUX_STREAM_COUNT_EN.
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             take_rdy,
    output logic [WIDTH-1:0] dout,
`ifdef DEMUX_STREAM_COUNT_EN
    output count_t           count,
`endif
    output logic             valid
);

    logic take;

    // A consumer ready with nothing buffered is not a transfer.
    assign take = valid & take_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                dout  <= din;
            end else if (take) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_STREAM_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (take) begin
            count <= count + count_t'(1);
        end
    end
`endif

endmodule

// File: rtl/demux_stream.sv
// Stream demux: one producer word routed to one of N one-entry channel slots (DEMUX_STREAM_COUNT_EN adds out_count).
// Latency 1 cycle input-to-out_valid; full throughput per channel when its consumer is ready.
// Backpressure: in_ready follows only the selected slot, so a stalled full channel blocks the input (head-of-line).
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter  int WIDTH = WORD_WIDTH,
    parameter  int N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [SW-1:0]                in_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N*WIDTH-1:0]           out_data,
    output logic [N-1:0]                 out_valid,
`ifdef DEMUX_STREAM_COUNT_EN
    output logic [N*COUNT_WIDTH-1:0]     out_count,
`endif
    input  logic [N-1:0]                 out_ready
);

    logic         accept;
    logic [N-1:0] load_en;

    // Free slot, or a slot being emptied this very cycle, can take the word.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load_en = '0;
        load_en[in_sel] = accept;
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load_en[k]),
            .din      (in_data),
            .take_rdy (out_ready[k]),
            .dout     (out_data[k*WIDTH +: WIDTH]),
`ifdef DEMUX_STREAM_COUNT_EN
            .count    (out_count[k*COUNT_WIDTH +: COUNT_WIDTH]),
`endif
            .valid    (out_valid[k])
        );
    end

endmodule
